// File: rtl/dt_pkg.sv
// Shared constants and FSM state type for the distance-transform engine and its
// post-processing stages.
package dt_pkg;
    localparam int DT_IMG_W  = 128;
    localparam int DT_PIXELS = DT_IMG_W * DT_IMG_W;
    localparam int DT_ADDR_W = 14;
    localparam int DT_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } dt_state_t;
endpackage

// File: rtl/dt_stat_scan_if.sv
// Read port of the DT result RAM: the scanner is the master (issues addresses), the
// RAM is the slave (returns data one cycle later).
interface dt_stat_scan_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
) ();
    logic              res_rd;
    logic [ADDR_W-1:0] res_addr;
    logic [DATA_W-1:0] res_di;

    modport master (output res_rd, output res_addr, input res_di);
    modport slave  (input res_rd, input res_addr, output res_di);
endinterface

// File: rtl/dt_stat_acc.sv
// Statistics datapath for the result scan: max/argmax, nonzero area and, when
// DTS_SUM_EN is defined, the sum of all distances.
module dt_stat_acc
    import dt_pkg::*;
#(
    parameter int ADDR_W = DT_ADDR_W,
    parameter int DATA_W = DT_DATA_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     valid,
    input  logic [ADDR_W-1:0]        idx,
    input  logic [DATA_W-1:0]        d,
    output logic [DATA_W-1:0]        max_val,
    output logic [ADDR_W-1:0]        max_addr,
`ifdef DTS_SUM_EN
    output logic [ADDR_W+DATA_W-1:0] dist_sum,
`endif
    output logic [ADDR_W:0]          area
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            max_val  <= '0;
            max_addr <= '0;
            area     <= '0;
        end else if (clr) begin
            max_val  <= '0;
            max_addr <= '0;
            area     <= '0;
        end else if (valid) begin
            // strict compare keeps the lowest address on ties
            if (d > max_val) begin
                max_val  <= d;
                max_addr <= idx;
            end
            if (d != '0)
                area <= area + (ADDR_W+1)'(1);
        end
    end

`ifdef DTS_SUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            dist_sum <= '0;
        else if (clr)
            dist_sum <= '0;
        else if (valid)
            dist_sum <= dist_sum + (ADDR_W+DATA_W)'(d);
    end
`endif

endmodule

// File: rtl/dt_stat_scan.sv
// Single raster scan of the DT result RAM after the engine finishes; reports max
// distance, its lowest address, object area and (with DTS_SUM_EN) the distance sum.
module dt_stat_scan
    import dt_pkg::*;
#(
    parameter int ADDR_W = DT_ADDR_W,
    parameter int DATA_W = DT_DATA_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    dt_stat_scan_if.master           res,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_W-1:0]        max_val,
    output logic [ADDR_W-1:0]        max_addr,
`ifdef DTS_SUM_EN
    output logic [ADDR_W+DATA_W-1:0] dist_sum,
`endif
    output logic [ADDR_W:0]          area
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    dt_state_t         state;
    logic              pend;
    logic [ADDR_W-1:0] idx;
    logic              clr;

    assign clr = (state == ST_IDLE) && start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            res.res_rd   <= 1'b0;
            res.res_addr <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pend         <= 1'b0;
            idx          <= '0;
        end else begin
            // RAM data lags the address by one cycle; pend/idx track that sample
            pend <= (state == ST_READ);
            idx  <= res.res_addr;
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state        <= ST_READ;
                        res.res_rd   <= 1'b1;
                        res.res_addr <= '0;
                        busy         <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (res.res_addr == LAST_ADDR) begin
                        state      <= ST_DRAIN;
                        res.res_rd <= 1'b0;
                    end else begin
                        res.res_addr <= res.res_addr + ADDR_W'(1);
                    end
                end
                ST_DRAIN: begin
                    state <= ST_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    dt_stat_acc #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_acc (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .valid    (pend),
        .idx      (idx),
        .d        (res.res_di),
        .max_val  (max_val),
        .max_addr (max_addr),
`ifdef DTS_SUM_EN
        .dist_sum (dist_sum),
`endif
        .area     (area)
    );

endmodule

// File: doc/dt_stat_scan.md
# dt_stat_scan

Post-processing stage directly downstream of the distance-transform engine. After the engine pulses `done`, this block scans the 128×128 byte result RAM once in raster order. It reports:
- the maximum distance and the lowest address holding it (the inscribed-circle centre),
- the object area (count of nonzero pixels),
- optionally, the sum of all distances.

Results feed the host status registers.

## Interface
- `ADDR_W`, 14: result-RAM address width; pixel count is 2^ADDR_W.
- `DATA_W`, 8: distance value width.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; wired to the DT engine `done`.
- `res_rd`  out  1  RAM read enable; high only while addresses are being issued.
- `res_addr`  out  ADDR_W  RAM read address.
- `res_di`  in  DATA_W  RAM read data; synchronous RAM, valid one cycle after `res_addr`.
- `busy`  out  1  scan in progress.
- `done`  out  1  one-cycle pulse; results valid.
- `max_val`  out  DATA_W  largest distance found.
- `max_addr`  out  ADDR_W  lowest address holding `max_val`.
- `area`  out  ADDR_W+1  number of pixels with `res_di != 0`.
- `dist_sum`  out  ADDR_W+DATA_W  sum of all distances (only with `DTS_SUM_EN`).

## Operation
- FSM states: IDLE → READ → DRAIN → DONE → IDLE.
- **IDLE**: `start` high moves to READ.
  - On that edge: `res_addr` ← 0 and all result registers are cleared.
- **READ**: `res_rd` = 1; `res_addr` increments by 1 per cycle.
  - At `res_addr` = 2^ADDR_W−1, go to DRAIN; the address stays at its final value, no wrap.
- **DRAIN**: `res_rd` = 0; accumulates the last data word; goes to DONE.
- **DONE**: `done` = 1 for exactly one cycle; goes to IDLE.
- A 1-bit `pend` register, set in READ, marks that `res_di` holds valid data. Accumulation happens in every cycle where `pend` = 1. Index of that data = `res_addr` delayed one cycle.
- Per valid sample `d` at index `a`:
  - if `d > max_val`, load `max_val` ← `d` and `max_addr` ← `a`. The compare is strict, so ties keep the lowest address.
  - if `d != 0`, increment `area`.
  - if `DTS_SUM_EN`, add `d` to `dist_sum`.
- Width rules:
  - `area` saturates only by range: maximum 2^ADDR_W, which fits ADDR_W+1 bits.
  - `dist_sum` cannot overflow: (2^DATA_W−1)·2^ADDR_W < 2^(ADDR_W+DATA_W).
- `start` is ignored outside IDLE, including the DONE cycle.
- Results hold after DONE until the next accepted `start`. During `busy` they are partial and must not be consumed.
- All-zero image: `max_val` = 0, `max_addr` = 0, `area` = 0, `dist_sum` = 0.

## Timing
- `start` sampled high at edge S.
- Cycle S+1: READ, `res_addr` = 0.
- Cycle S+1+k: `res_addr` = k.
- Data for address k is accumulated at the end of cycle S+2+k.
- DRAIN in cycle S+2^ADDR_W+1; `done` high in cycle S+2^ADDR_W+2. That is cycle S+16386 at defaults.
- `busy` is high from cycle S+1 through the DRAIN cycle; it is low in DONE and IDLE.
- Reset values: state IDLE; `res_rd`, `busy`, `done` = 0; `res_addr`, `max_val`, `max_addr`, `area`, `dist_sum`, `pend` = 0.
- Reset asserted mid-scan aborts immediately: all outputs go to their reset values and no `done` is produced. A `start` after release begins a fresh scan.

## Configuration
- `DTS_SUM_EN` defined: the `dist_sum` port and its accumulator exist.
- `DTS_SUM_EN` undefined: the port and the adder are absent. All other behaviour and timing are identical.

## Structure
- Shared package `dt_pkg` holds:
  - the FSM state enum (`ST_IDLE`, `ST_READ`, `ST_DRAIN`, `ST_DONE`),
  - `DT_IMG_W` = 128 and `DT_PIXELS` = 16384 constants,
  - the default widths, which are also used by the DT engine.
- Sub-module `dt_stat_acc` is the accumulation datapath: sample valid, index, data in; max/argmax/area/sum registers out. The parent block holds the FSM and address counter.

## Test plan
- Reset, then `start` with an all-zero RAM → `done` at S+16386; `max_val` 0, `max_addr` 0, `area` 0, `dist_sum` 0.
- RAM[5000] = 7, RAM[9000] = 7, all else 0 → `max_val` 7, `max_addr` 5000, `area` 2, `dist_sum` 14.
- Every location = 255 → `max_val` 255, `max_addr` 0, `area` 16384, `dist_sum` 4177920.
- Only RAM[16383] = 3 (last-address/drain path) → `max_val` 3, `max_addr` 16383, `area` 1.
- Extra `start` pulses at S+100 and during DONE → no restart; exactly one `done` at S+16386.
- `reset` asserted at S+8000 → all outputs 0 next cycle and no `done`. A new `start` then completes normally with correct results.
